// File: rtl/idli_pkg.sv
// Shared types and constants for the idli UART blocks.
package idli_pkg;

  localparam int UART_BITS_PER_CHAR = 8;
  localparam int UART_NIBBLE_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/idli_uart_tx_if.sv
// Nibble handshake from EX into the UART TX block, plus the serial line and status.
interface idli_uart_tx_if;
  import idli_pkg::*;

  logic                     vld;
  logic [UART_NIBBLE_W-1:0] data;
  logic                     acp;
  logic                     tx;
  logic                     busy;

  modport master (output vld, data, input acp, tx, busy);
  modport slave  (input vld, data, output acp, tx, busy);

endinterface

// File: rtl/idli_uart_fifo_m.sv
// Small synchronous FIFO with occupancy count; shared by the UART TX and RX paths.
module idli_uart_fifo_m #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/idli_uart_tx_m.sv
// UART transmitter: assembles nibble pairs into bytes, queues them and sends 8N1 frames LSB first.
// Clocked by the ungated core clock so the queue keeps draining while the core is stalled.
module idli_uart_tx_m
  import idli_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           i_uart_tx_gck,
  input  logic           i_uart_tx_rst_n,
  idli_uart_tx_if.slave  uart
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int RES_W  = CNT_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_BITS_PER_CHAR);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(UART_BITS_PER_CHAR - 1);

  logic                     phase_q;
  logic                     drop_q;
  logic [UART_NIBBLE_W-1:0] lo_q;
  logic                     push;
  logic [7:0]               push_data;
  logic                     pop;
  logic [7:0]               pop_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [RES_W-1:0]         reserved;
  logic                     acp;

  uart_tx_state_t           state_q;
  uart_tx_state_t           state_d;
  logic [BAUD_W-1:0]        baud_q;
  logic [BAUD_W-1:0]        baud_d;
  logic [BIT_W-1:0]         bit_q;
  logic [BIT_W-1:0]         bit_d;
  logic [7:0]               shift_q;
  logic [7:0]               shift_d;
  logic                     tx_q;
  logic                     tx_d;

  // A staged low nibble reserves a FIFO slot, so acp depends on registered state only.
  assign reserved = {1'b0, fifo_count} + {{CNT_W{1'b0}}, phase_q};
  assign acp      = (reserved < RES_W'(DEPTH));

  assign push      = phase_q && uart.vld;
  assign push_data = {uart.data, lo_q};

  always_ff @(posedge i_uart_tx_gck) begin
    if (!i_uart_tx_rst_n) begin
      phase_q <= 1'b0;
      drop_q  <= 1'b0;
      lo_q    <= '0;
    end else if (phase_q) begin
      phase_q <= 1'b0;
    end else if (drop_q) begin
      drop_q  <= 1'b0;
    end else if (uart.vld) begin
      if (acp) begin
        lo_q    <= uart.data;
        phase_q <= 1'b1;
      end else begin
        drop_q  <= 1'b1;
      end
    end
  end

  idli_uart_fifo_m #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (i_uart_tx_gck),
    .rst_n     (i_uart_tx_rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge i_uart_tx_gck) begin
    if (!i_uart_tx_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // The line level is derived from the next state so it changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = pop_data;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          state_d = IDLE;
        end else begin
          baud_d  = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign uart.acp  = acp;
  assign uart.tx   = tx_q;
  assign uart.busy = (fifo_count != '0) || phase_q || (state_q != IDLE);

  // Protocol checks on the EX side; the RTL above recovers if they ever fire.
  always_ff @(posedge i_uart_tx_gck) begin
    if (i_uart_tx_rst_n) begin
      assert (!phase_q || uart.vld);
      assert (phase_q || drop_q || !uart.vld || acp);
      assert (!(push && fifo_full));
    end
  end

endmodule

// File: doc/idli_uart_tx_m.md
Name: idli_uart_tx_m

Overview:
UART transmit side of the core's UART interface. Accepts bytes from EX as two consecutive 4-bit nibbles, buffers them in a small byte FIFO and serialises them as 8N1 frames, LSB first, on the TX line. Drives the accept signal the sync block uses to stall UART TX instructions. Runs on the ungated core clock so draining continues while the core is stalled.

Parameters:
DEPTH, 4, byte FIFO entries; power of two, >= 2.
CLKS_PER_BIT, 16, clock cycles per UART bit; >= 2.

Ports:
i_uart_tx_gck  input  1  ungated core clock.
i_uart_tx_rst_n  input  1  reset; synchronous, active-low.
i_uart_tx_vld  input  1  nibble valid from EX; high for exactly 2 consecutive cycles per byte.
i_uart_tx_data  input  4  nibble; low nibble on the 1st valid cycle, high nibble on the 2nd.
o_uart_tx_acp  output  1  one byte can be accepted; a new byte may start only while high.
o_uart_tx  output  1  serial line; idle high.
o_uart_tx_busy  output  1  FIFO non-empty, a byte staged, or a frame in flight.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-low. All state updates on posedge i_uart_tx_gck.
- Reset values: o_uart_tx=1, o_uart_tx_acp=1, o_uart_tx_busy=0. FIFO empty, nothing staged, FSM IDLE, counters 0.
- Nibble capture:
  - Phase flag, 0 after reset.
  - Phase 0 with vld: store data in lo_q, set phase=1, set staged=1.
  - Phase 1 with vld: push {data, lo_q} into the FIFO, clear phase and staged.
  - Phase 1 without vld: protocol error. Assert in simulation. RTL discards the staged nibble and returns to phase 0.
- Accept:
  - o_uart_tx_acp = (count + staged) < DEPTH.
  - Registered state only; no combinational path from i_uart_tx_vld.
  - Starting a byte (phase-0 vld) while acp=0 is illegal. Assert in simulation. RTL drops the byte and leaves the FIFO unchanged.
- FIFO:
  - Rd/wr pointers log2(DEPTH) bits, wrapping naturally. Count is log2(DEPTH)+1 bits.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - The staging reservation guarantees a push is never made to a full FIFO.
- Serialiser FSM (states IDLE, START, DATA, STOP):
  - IDLE: line=1. If the FIFO is non-empty, pop into shift_q, load baud counter with CLKS_PER_BIT-1, go to START. A byte pushed in cycle N can be popped in N+1 at the earliest.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line=shift_q[0], held CLKS_PER_BIT cycles per bit, then shift right. After bit index 7, go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE lasts at least one cycle between frames, so back-to-back frames have a stop bit of CLKS_PER_BIT+1 cycles.
  - o_uart_tx is registered. Its first low cycle is the cycle after the START entry edge.
- Baud counter: counts down from CLKS_PER_BIT-1; the state or bit advances when it reaches 0. Width is $clog2(CLKS_PER_BIT).
- Busy: o_uart_tx_busy = (count != 0) || staged || (state != IDLE).
- Reset mid-operation: reset during a frame forces the line high in the next cycle and discards the FIFO and the staged nibble. No partial-frame completion.

Decomposition:
- idli_pkg gets `uart_tx_state_t` (IDLE, START, DATA, STOP) and `UART_BITS_PER_CHAR = 8`.
- The byte FIFO is a natural sub-module: idli_uart_fifo_m, parameterised on DEPTH and WIDTH, with push/pop/full/empty/count.
  - It is reused later by the UART RX path.
- Serialiser FSM and nibble capture stay in idli_uart_tx_m.

Test Plan:
- Reset idle: hold rst_n=0 for 3 cycles, then release -> o_uart_tx=1, acp=1, busy=0 on every cycle until a nibble arrives.
- Single byte: nibbles 0x5 then 0xA (byte 0xA5), CLKS_PER_BIT=16 -> line idles 1, then 16 cycles of 0, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 16 cycles of 1 -> busy drops after STOP.
- Fill and backpressure: DEPTH=4, send 5 bytes back-to-back while the first frame is in flight -> acp falls after byte 5's low nibble (FIFO holds 3, one staged, one serialising); acp returns high the cycle after the next pop.
- Simultaneous push/pop: high nibble arrives on the same cycle the FSM pops from a FIFO holding 1 entry -> count stays 1, and both bytes are later transmitted in order.
- Wrap-around: stream 10 bytes 0x00..0x09 with DEPTH=4 -> the decoded line output equals the input sequence with no loss or reordering.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 2 bytes queued -> line=1 in the next cycle, busy=0, and no further frames after release.
